ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Companion to the PS/2 receiver. Shares the PS2_KBCLK/PS2_KBDAT lines through open-drain drive.
- tx_idle gates the receiver's rx_en so the receiver ignores the host frame.
- Sits beside the keyboard receiver in the top level; driven by game/control logic.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_clk_filter.sv | 48 ++++
 rtl/ps2_host_tx.sv | 159 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host FSM state encodings, keyboard command bytes
// and the frame builder used by the host transmitter.
package ps2_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RTS      = 3'd1;
    localparam logic [2:0] ST_START    = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_STOP     = 3'd4;
    localparam logic [2:0] ST_ACK      = 3'd5;
    localparam logic [2:0] ST_WAIT_REL = 3'd6;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] ACK_BYTE    = 8'hFA;

    // Odd parity above the data byte; shifted out LSB first.
    function automatic logic [8:0] ps2_frame(input logic [7:0] data);
        return {~^data, data};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioner: two-flop synchroniser, run-length glitch filter and
// a one-cycle strobe on each filtered 1->0 transition.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic CLOCK_50,
    input  logic frame_reset,
    input  logic ps2c_in,
    output logic ps2c_filt,
    output logic fall_edge
);

    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic [FILTER_LEN-1:0] shreg_q, shreg_d;
    logic                  filt_q, filt_d;

    always_comb begin
        sync1_d = ps2c_in;
        sync2_d = sync1_q;
        shreg_d = {shreg_q[FILTER_LEN-2:0], sync2_q};
        filt_d  = filt_q;
        if (&shreg_d) begin
            filt_d = 1'b1;
        end else if (~|shreg_d) begin
            filt_d = 1'b0;
        end
    end

    // Idle bus is pulled high, so everything resets to 1 to avoid a false edge.
    always_ff @(posedge CLOCK_50 or posedge frame_reset) begin
        if (frame_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            shreg_q <= '1;
            filt_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            shreg_q <= shreg_d;
            filt_q  <= filt_d;
        end
    end

    assign ps2c_filt = filt_q;
    assign fall_edge = filt_q & ~filt_d;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame clocked by the
// device, ACK check and bus release, with a per-edge timeout watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       CLOCK_50,
    input  logic       frame_reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       sreg_q, sreg_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             d_sync1_q, d_sync1_d;
    logic             d_sync2_q, d_sync2_d;
    logic             ps2c_filt, fall_edge;
    logic             c_oe, d_oe, timed;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .CLOCK_50   (CLOCK_50),
        .frame_reset(frame_reset),
        .ps2c_in    (ps2c),
        .ps2c_filt  (ps2c_filt),
        .fall_edge  (fall_edge)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sreg_d       = sreg_q;
        bit_cnt_d    = bit_cnt_q;
        d_sync1_d    = ps2d;
        d_sync2_d    = d_sync1_q;
        c_oe         = 1'b0;
        d_oe         = 1'b0;
        tx_done_tick = 1'b0;
        tx_err       = 1'b0;
        timed        = (state_q != ST_IDLE) && (state_q != ST_RTS);

        case (state_q)
            ST_IDLE: begin
                if (wr_ps2) begin
                    sreg_d  = ps2_frame(din);
                    cnt_d   = '0;
                    state_d = ST_RTS;
                end
            end
            ST_RTS: begin
                c_oe  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RTS_LAST) begin
                    d_oe    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                d_oe  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (fall_edge) begin
                    cnt_d     = '0;
                    bit_cnt_d = 4'd8;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                d_oe  = ~sreg_q[0];
                cnt_d = cnt_q + 1'b1;
                if (fall_edge) begin
                    cnt_d = '0;
                    if (bit_cnt_q == 4'd0) begin
                        state_d = ST_STOP;
                    end else begin
                        sreg_d    = {1'b0, sreg_q[8:1]};
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
            end
            ST_STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (fall_edge) begin
                    cnt_d   = '0;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                cnt_d = cnt_q + 1'b1;
                if (fall_edge) begin
                    cnt_d = '0;
                    if (!d_sync2_q) begin
                        state_d = ST_WAIT_REL;
                    end else begin
                        tx_err  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_REL: begin
                cnt_d = cnt_q + 1'b1;
                if (ps2c_filt && d_sync2_q) begin
                    tx_done_tick = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Watchdog overrides whatever the state wanted this cycle.
        if (timed && cnt_q == TO_LIMIT) begin
            c_oe         = 1'b0;
            d_oe         = 1'b0;
            tx_done_tick = 1'b0;
            tx_err       = 1'b1;
            cnt_d        = '0;
            state_d      = ST_IDLE;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge frame_reset) begin
        if (frame_reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            d_sync1_q <= 1'b1;
            d_sync2_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            d_sync1_q <= d_sync1_d;
            d_sync2_q <= d_sync2_d;
        end
    end

    assign tx_idle = (state_q == ST_IDLE);
    assign ps2c    = c_oe ? 1'b0 : 1'bz;
    assign ps2d    = d_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host while a scoreboard monitor checks every done/err pulse it produces.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 100;
    localparam int TO   = 300;
    localparam int FL   = 8;
    localparam int HALF = 25;

    logic       clk = 1'b0;
    logic       frame_reset;
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle, tx_done_tick, tx_err;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    wire        ps2c_w, ps2d_w;

    pullup (ps2c_w);
    pullup (ps2d_w);
    assign ps2c_w = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d_w = dev_d_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .CLOCK_50    (clk),
        .frame_reset (frame_reset),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c        (ps2c_w),
        .ps2d        (ps2d_w),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_err      (tx_err)
    );

    typedef struct {
        bit          is_err;
        bit          chk_to;
        logic [10:0] bits;
        int          nbits;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_fall_cyc = 0;
    int          txn      = 0;
    logic [10:0] obs_bits = '0;
    bit          idle_pending = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole frame as the device sees it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b, 1'b0};
    endfunction

    // Monitor: pops the scoreboard on every pulse the DUT raises.
    always @(negedge clk) begin
        exp_t        e;
        logic [10:0] mask;
        if (idle_pending) begin
            check("idle_after_pulse", tx_idle, 1);
            idle_pending = 1'b0;
        end
        if (tx_done_tick && tx_err) check("done_err_exclusive", 2, 1);
        if (tx_done_tick || tx_err) begin
            check("idle_low_at_pulse", tx_idle, 0);
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {tx_done_tick, tx_err}, 0);
            end else begin
                e = sb_q.pop_front();
                txn++;
                mask = 11'((1 << e.nbits) - 1);
                check("pulse_kind_err", tx_err, e.is_err);
                check("frame_bits", obs_bits & mask, e.bits & mask);
                if (e.chk_to) check("timeout_latency", cyc - last_fall_cyc, TO + FL + 2);
                $display("txn %0d: %s bits=%b expected=%b nbits=%0d", txn,
                         tx_err ? "err " : "done", obs_bits & mask, e.bits & mask, e.nbits);
            end
            idle_pending = 1'b1;
        end
    end

    task automatic dev_frame(input int n_falls, input bit give_ack, input bit glitch,
                             input bit wr_mid, input logic [7:0] mid_din);
        int w;
        int low_len;
        int d_low;
        obs_bits = '0;
        w = 0;
        while (ps2c_w !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            check("rts_seen", 0, 1);
            return;
        end
        low_len = 0;
        d_low   = 0;
        while (ps2c_w === 1'b0 && low_len < 4 * INH) begin
            if (ps2d_w === 1'b0) d_low++;
            low_len++;
            @(negedge clk);
        end
        check("rts_len", low_len, INH);
        check("rts_data_low_cycles", d_low, 1);
        check("start_bit_held", ps2d_w, 0);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (i >= n_falls) break;
            if (i <= 10) obs_bits[i] = ps2d_w;
            dev_c_low     = 1'b1;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b0;
            if (i == 10 && give_ack) dev_d_low = 1'b1;
            if (i == 11) dev_d_low = 1'b0;
            if (glitch && i == 4) begin
                repeat (8) @(negedge clk);
                dev_c_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_c_low = 1'b0;
                repeat (HALF - 11) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (wr_mid && i == 6) begin
                din    = mid_din;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
        end
        dev_d_low = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (!(tx_idle === 1'b1 && !idle_pending) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) check("idle_wait_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input int n_falls, input bit ack,
                        input bit glitch, input bit wr_mid);
        exp_t e;
        e.bits   = model_frame(b);
        e.is_err = !(n_falls == 12 && ack);
        e.chk_to = (n_falls < 12);
        e.nbits  = (n_falls < 11) ? n_falls : 11;
        sb_q.push_back(e);
        @(negedge clk);
        din    = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        dev_frame(n_falls, ack, glitch, wr_mid, 8'($urandom_range(0, 255)));
        wait_idle();
        check("ps2c_released", ps2c_w, 1);
        check("ps2d_released", ps2d_w, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_reset = 1'b1;
        wr_ps2      = 1'b0;
        din         = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx_idle", tx_idle, 1);
        check("reset_done", tx_done_tick, 0);
        check("reset_err", tx_err, 0);
        check("reset_ps2c", ps2c_w, 1);
        check("reset_ps2d", ps2d_w, 1);
        frame_reset = 1'b0;
        repeat (3) @(negedge clk);

        send(CMD_SET_LED, 12, 1'b1, 1'b0, 1'b0);
        send(CMD_RESET, 12, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) send(8'($urandom_range(0, 255)), 12, 1'b1, 1'b0, 1'b0);
        send(8'($urandom_range(0, 255)), 12, 1'b0, 1'b0, 1'b0);
        send(8'($urandom_range(0, 255)), 5, 1'b1, 1'b0, 1'b0);

        // Abort in the middle of the data bits of an all-zero byte.
        @(negedge clk);
        din    = 8'h00;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        dev_frame(4, 1'b0, 1'b0, 1'b0, 8'h00);
        check("pre_reset_data_low", ps2d_w, 0);
        frame_reset = 1'b1;
        #1;
        check("abort_ps2d_released", ps2d_w, 1);
        check("abort_ps2c_released", ps2c_w, 1);
        check("abort_tx_idle", tx_idle, 1);
        repeat (3) @(negedge clk);
        frame_reset = 1'b0;
        repeat (TO + 50) @(negedge clk);
        check("abort_no_pending", sb_q.size(), 0);

        send(CMD_ENABLE, 12, 1'b1, 1'b0, 1'b0);
        send(8'($urandom_range(0, 255)), 12, 1'b1, 1'b1, 1'b1);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
